// File: rtl/app_wr_buf_arb_pkg.sv
// Shared definitions for the app write-buffer arbiter.
//   - default requester count and beat-counter width
//   - state encoding of the arbiter FSM
package app_wr_buf_arb_pkg;

    localparam int unsigned WR_BUF_NUM_REQ_DEF    = 4;
    localparam int unsigned WR_BUF_BEAT_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        WB_ARB_IDLE = 2'd0,
        WB_ARB_REQ  = 2'd1,
        WB_ARB_DATA = 2'd2,
        WB_ARB_DONE = 2'd3
    } wb_arb_state_e;

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Combinational round-robin pick.
// Ports:
//   req_i      - request vector, one bit per requester
//   rr_ptr_i   - highest-priority index for this pick
//   gnt_oh_o   - one-hot winner (all zero when nobody requests)
//   gnt_idx_o  - binary index of the winner (0 when nobody requests)
module rr_arbiter_ptr #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [REQ_IDX_W-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]   gnt_oh_o,
    output logic [REQ_IDX_W-1:0] gnt_idx_o
);

    always_comb begin
        int unsigned j;
        logic        found;
        j         = 0;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        // Scan from rr_ptr upward, wrapping at NUM_REQ; first hit wins.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(rr_ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_i[j[REQ_IDX_W-1:0]]) begin
                found                        = 1'b1;
                gnt_oh_o[j[REQ_IDX_W-1:0]]   = 1'b1;
                gnt_idx_o                    = j[REQ_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/app_wr_buf_arb.sv
// Shares one wr_buf engine between NUM_REQ app controllers. A winner is
// chosen round-robin and owns the engine from grant until its completion
// handshake; request, payload and completion channels of the owner are
// routed straight through, all other requesters see rdy/done low.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   src_wr_buf_req_* / wr_buf_src_*  - per-requester request/payload/done
//   arb_wr_buf_* / wr_buf_arb_*      - shared engine side handshakes
//   arb_grant_idx, arb_grant_val     - current owner (payload mux select)
//   arb_beat_cnt                     - payload beats accepted this transaction
//
// state | meaning
// IDLE  | no owner; arbitrate among req_val, nothing ready
// REQ   | owner's request forwarded to engine
// DATA  | owner's payload beats forwarded, beats counted
// DONE  | engine completion forwarded to owner; pointer advances on handshake
module app_wr_buf_arb
    import app_wr_buf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = WR_BUF_NUM_REQ_DEF,
    parameter int unsigned REQ_IDX_W  = $clog2(NUM_REQ),
    parameter int unsigned BEAT_CNT_W = WR_BUF_BEAT_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    src_wr_buf_req_val,
    output logic [NUM_REQ-1:0]    wr_buf_src_req_rdy,
    input  logic [NUM_REQ-1:0]    src_wr_buf_req_data_val,
    input  logic [NUM_REQ-1:0]    src_wr_buf_req_data_last,
    output logic [NUM_REQ-1:0]    wr_buf_src_req_data_rdy,
    output logic [NUM_REQ-1:0]    wr_buf_src_req_done,
    input  logic [NUM_REQ-1:0]    src_wr_buf_done_rdy,
    output logic                  arb_wr_buf_req_val,
    input  logic                  wr_buf_arb_req_rdy,
    output logic                  arb_wr_buf_req_data_val,
    input  logic                  wr_buf_arb_req_data_rdy,
    input  logic                  wr_buf_arb_req_done,
    output logic                  arb_wr_buf_done_rdy,
    output logic [REQ_IDX_W-1:0]  arb_grant_idx,
    output logic                  arb_grant_val,
    output logic [BEAT_CNT_W-1:0] arb_beat_cnt
);

    wb_arb_state_e         state_q;
    logic [REQ_IDX_W-1:0]  rr_ptr_q;
    logic [REQ_IDX_W-1:0]  rr_ptr_d;
    logic [REQ_IDX_W-1:0]  grant_idx_q;
    logic                  grant_val_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_q;

    logic [NUM_REQ-1:0]    arb_oh;
    logic [REQ_IDX_W-1:0]  arb_idx;
    logic                  req_hs;
    logic                  data_hs;
    logic                  done_hs;

    rr_arbiter_ptr #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_rr_arbiter_ptr (
        .req_i     (src_wr_buf_req_val),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    assign req_hs  = src_wr_buf_req_val[grant_idx_q] & wr_buf_arb_req_rdy;
    assign data_hs = src_wr_buf_req_data_val[grant_idx_q] & wr_buf_arb_req_data_rdy;
    assign done_hs = wr_buf_arb_req_done & src_wr_buf_done_rdy[grant_idx_q];

    assign rr_ptr_d = (grant_idx_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WB_ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            grant_val_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            case (state_q)
                WB_ARB_IDLE: begin
                    if (|arb_oh) begin
                        grant_idx_q <= arb_idx;
                        grant_val_q <= 1'b1;
                        beat_cnt_q  <= '0;
                        state_q     <= WB_ARB_REQ;
                    end
                end
                WB_ARB_REQ: begin
                    if (req_hs) begin
                        state_q <= WB_ARB_DATA;
                    end
                end
                WB_ARB_DATA: begin
                    if (data_hs) begin
                        if (beat_cnt_q != {BEAT_CNT_W{1'b1}}) begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                        if (src_wr_buf_req_data_last[grant_idx_q]) begin
                            state_q <= WB_ARB_DONE;
                        end
                    end
                end
                WB_ARB_DONE: begin
                    if (done_hs) begin
                        rr_ptr_q    <= rr_ptr_d;
                        grant_val_q <= 1'b0;
                        state_q     <= WB_ARB_IDLE;
                    end
                end
                default: state_q <= WB_ARB_IDLE;
            endcase
        end
    end

    // Handshake routing. Gated by rst_n so nothing is offered during the
    // reset cycle itself, even when reset lands mid-transaction.
    always_comb begin
        wr_buf_src_req_rdy      = '0;
        wr_buf_src_req_data_rdy = '0;
        wr_buf_src_req_done     = '0;
        arb_wr_buf_req_val      = 1'b0;
        arb_wr_buf_req_data_val = 1'b0;
        arb_wr_buf_done_rdy     = 1'b0;
        if (rst_n) begin
            case (state_q)
                WB_ARB_REQ: begin
                    arb_wr_buf_req_val              = src_wr_buf_req_val[grant_idx_q];
                    wr_buf_src_req_rdy[grant_idx_q] = wr_buf_arb_req_rdy;
                end
                WB_ARB_DATA: begin
                    arb_wr_buf_req_data_val              = src_wr_buf_req_data_val[grant_idx_q];
                    wr_buf_src_req_data_rdy[grant_idx_q] = wr_buf_arb_req_data_rdy;
                end
                WB_ARB_DONE: begin
                    wr_buf_src_req_done[grant_idx_q] = wr_buf_arb_req_done;
                    arb_wr_buf_done_rdy              = src_wr_buf_done_rdy[grant_idx_q];
                end
                default: ;
            endcase
        end
    end

    assign arb_grant_idx = grant_idx_q;
    assign arb_grant_val = grant_val_q & rst_n;
    assign arb_beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_app_wr_buf_arb.sv
module tb_app_wr_buf_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  src_wr_buf_req_val;
    logic [N-1:0]  wr_buf_src_req_rdy;
    logic [N-1:0]  src_wr_buf_req_data_val;
    logic [N-1:0]  src_wr_buf_req_data_last;
    logic [N-1:0]  wr_buf_src_req_data_rdy;
    logic [N-1:0]  wr_buf_src_req_done;
    logic [N-1:0]  src_wr_buf_done_rdy;
    logic          arb_wr_buf_req_val;
    logic          wr_buf_arb_req_rdy;
    logic          arb_wr_buf_req_data_val;
    logic          wr_buf_arb_req_data_rdy;
    logic          wr_buf_arb_req_done;
    logic          arb_wr_buf_done_rdy;
    logic [1:0]    arb_grant_idx;
    logic          arb_grant_val;
    logic [15:0]   arb_beat_cnt;

    app_wr_buf_arb #(.NUM_REQ(4), .REQ_IDX_W(2), .BEAT_CNT_W(16)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .src_wr_buf_req_val       (src_wr_buf_req_val),
        .wr_buf_src_req_rdy       (wr_buf_src_req_rdy),
        .src_wr_buf_req_data_val  (src_wr_buf_req_data_val),
        .src_wr_buf_req_data_last (src_wr_buf_req_data_last),
        .wr_buf_src_req_data_rdy  (wr_buf_src_req_data_rdy),
        .wr_buf_src_req_done      (wr_buf_src_req_done),
        .src_wr_buf_done_rdy      (src_wr_buf_done_rdy),
        .arb_wr_buf_req_val       (arb_wr_buf_req_val),
        .wr_buf_arb_req_rdy       (wr_buf_arb_req_rdy),
        .arb_wr_buf_req_data_val  (arb_wr_buf_req_data_val),
        .wr_buf_arb_req_data_rdy  (wr_buf_arb_req_data_rdy),
        .wr_buf_arb_req_done      (wr_buf_arb_req_done),
        .arb_wr_buf_done_rdy      (arb_wr_buf_done_rdy),
        .arb_grant_idx            (arb_grant_idx),
        .arb_grant_val            (arb_grant_val),
        .arb_beat_cnt             (arb_beat_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Requester behaviour: want[i] transactions pending, nbeats[i] beats each.
    int       want[N];
    int       nbeats[N];
    int       beats_left[N];
    int       req_rise[N];
    bit       bp_en = 1'b0;
    bit       bp_ph = 1'b0;
    logic [N-1:0] hs_req = '0, hs_data = '0, hs_done = '0;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                beats_left[i] = 0;
            end else begin
                if (hs_req[i])  beats_left[i] = nbeats[i];
                if (hs_data[i]) beats_left[i] = beats_left[i] - 1;
                if (hs_done[i]) want[i] = want[i] - 1;
            end
            if (want[i] > 0 && !src_wr_buf_req_val[i]) req_rise[i] = cyc;
            src_wr_buf_req_val[i]       = (want[i] > 0);
            src_wr_buf_req_data_val[i]  = (beats_left[i] > 0);
            src_wr_buf_req_data_last[i] = (beats_left[i] == 1);
        end
        bp_ph = ~bp_ph;
        wr_buf_arb_req_data_rdy = bp_en ? bp_ph : 1'b1;
    end

    // Event logs for hand-computed checks.
    typedef struct { int idx; int cyc; int beats; int vec; } ev_t;
    ev_t g_log[$];
    ev_t d_log[$];
    logic prev_gval = 1'b0;

    function automatic ev_t gev(input int i);
        ev_t e = '{-1, -1, -1, -1};
        if (i < g_log.size()) e = g_log[i];
        return e;
    endfunction

    function automatic ev_t dev(input int i);
        ev_t e = '{-1, -1, -1, -1};
        if (i < d_log.size()) e = d_log[i];
        return e;
    endfunction

    // Reference model: who owns the engine and which phase of its
    // transaction it is in (0 request, 1 payload, 2 completion).
    int m_owner = -1;
    int m_ph    = 0;
    int m_beats = 0;
    int m_rr    = 0;
    logic [N-1:0] e_rrdy, e_drdy, e_done;
    logic e_rval, e_dval, e_dnrdy, e_gval;

    always @(negedge clk) begin
        e_rrdy = '0; e_drdy = '0; e_done = '0;
        e_rval = 1'b0; e_dval = 1'b0; e_dnrdy = 1'b0;
        e_gval = rst_n && (m_owner >= 0);
        if (e_gval) begin
            if (m_ph == 0) begin
                e_rval = src_wr_buf_req_val[m_owner];
                e_rrdy[m_owner] = wr_buf_arb_req_rdy;
            end else if (m_ph == 1) begin
                e_dval = src_wr_buf_req_data_val[m_owner];
                e_drdy[m_owner] = wr_buf_arb_req_data_rdy;
            end else begin
                e_done[m_owner] = wr_buf_arb_req_done;
                e_dnrdy = src_wr_buf_done_rdy[m_owner];
            end
        end
        chk("req_rdy",   int'(wr_buf_src_req_rdy),      int'(e_rrdy));
        chk("data_rdy",  int'(wr_buf_src_req_data_rdy), int'(e_drdy));
        chk("src_done",  int'(wr_buf_src_req_done),     int'(e_done));
        chk("arb_req_val",  int'(arb_wr_buf_req_val),      int'(e_rval));
        chk("arb_data_val", int'(arb_wr_buf_req_data_val), int'(e_dval));
        chk("arb_done_rdy", int'(arb_wr_buf_done_rdy),     int'(e_dnrdy));
        chk("grant_val", int'(arb_grant_val), int'(e_gval));
        chk("beat_cnt",  int'(arb_beat_cnt),  m_beats);
        if (e_gval) chk("grant_idx", int'(arb_grant_idx), m_owner);

        hs_req  = wr_buf_src_req_rdy & src_wr_buf_req_val;
        hs_data = wr_buf_src_req_data_rdy & src_wr_buf_req_data_val;
        hs_done = wr_buf_src_req_done & src_wr_buf_done_rdy;

        if (arb_grant_val && !prev_gval)
            g_log.push_back('{int'(arb_grant_idx), cyc, 0, 0});
        prev_gval = arb_grant_val;
        if (|hs_done)
            d_log.push_back('{int'(arb_grant_idx), cyc + 1, int'(arb_beat_cnt), int'(wr_buf_src_req_done)});

        if (!rst_n) begin
            m_owner = -1; m_ph = 0; m_beats = 0; m_rr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && src_wr_buf_req_val[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
            if (m_owner >= 0) begin
                m_ph = 0; m_beats = 0;
            end
        end else if (m_ph == 0) begin
            if (src_wr_buf_req_val[m_owner] && wr_buf_arb_req_rdy) m_ph = 1;
        end else if (m_ph == 1) begin
            if (src_wr_buf_req_data_val[m_owner] && wr_buf_arb_req_data_rdy) begin
                if (m_beats < 65535) m_beats = m_beats + 1;
                if (src_wr_buf_req_data_last[m_owner]) m_ph = 2;
            end
        end else begin
            if (wr_buf_arb_req_done && src_wr_buf_done_rdy[m_owner]) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) want[i] = 0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        g_log.delete();
        d_log.delete();
    endtask

    task automatic wait_done(input int n, input int budget);
        int b = 0;
        while (d_log.size() < n && b < budget) begin
            step(1);
            b++;
        end
        chk("wait_done_count", d_log.size(), n);
    endtask

    task automatic wait_grant(input int idx, input int budget);
        int b = 0;
        while (!(arb_grant_val && int'(arb_grant_idx) == idx) && b < budget) begin
            step(1);
            b++;
        end
        chk("wait_grant", int'(arb_grant_val && int'(arb_grant_idx) == idx), 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b = 0;
        while (!(arb_grant_val && int'(arb_beat_cnt) == n) && b < budget) begin
            step(1);
            b++;
        end
        chk("wait_beats", int'(arb_beat_cnt), n);
    endtask

    int fair_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        src_wr_buf_req_val       = '0;
        src_wr_buf_req_data_val  = '0;
        src_wr_buf_req_data_last = '0;
        src_wr_buf_done_rdy      = '1;
        wr_buf_arb_req_rdy       = 1'b1;
        wr_buf_arb_req_data_rdy  = 1'b1;
        wr_buf_arb_req_done      = 1'b1;
        for (int i = 0; i < N; i++) begin
            want[i] = 1; nbeats[i] = 1; beats_left[i] = 0; req_rise[i] = 0;
        end

        // Reset held with every requester asking.
        rst_n = 1'b0;
        step(2);
        chk("rst_req_val_seen", int'(src_wr_buf_req_val), 15);
        chk("rst_grant_val", int'(arb_grant_val), 0);
        chk("rst_any_rdy", int'(|{wr_buf_src_req_rdy, wr_buf_src_req_data_rdy, wr_buf_src_req_done}), 0);
        chk("rst_shared", int'(arb_wr_buf_req_val | arb_wr_buf_req_data_val | arb_wr_buf_done_rdy), 0);
        chk("rst_beat_cnt", int'(arb_beat_cnt), 0);
        do_reset();

        // Single requester 2, three beats.
        clear_logs();
        want[2] = 1; nbeats[2] = 3;
        wait_done(1, 50);
        chk("single_grant_idx", gev(0).idx, 2);
        chk("single_grant_latency", gev(0).cyc - req_rise[2], 1);
        chk("single_done_idx", dev(0).idx, 2);
        chk("single_beats", dev(0).beats, 3);
        chk("single_done_vec", dev(0).vec, 4);

        // Back-to-back on requester 0: one idle cycle in between.
        step(1);
        clear_logs();
        want[0] = 2; nbeats[0] = 1;
        wait_done(2, 60);
        chk("b2b_grant0", gev(0).idx, 0);
        chk("b2b_grant1", gev(1).idx, 0);
        chk("b2b_gap", gev(1).cyc - dev(0).cyc, 1);
        chk("b2b_beats", dev(1).beats, 1);

        // Fairness from a fresh pointer.
        step(1);
        do_reset();
        clear_logs();
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        for (int i = 0; i < N; i++) nbeats[i] = 1;
        wait_done(5, 100);
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", gev(k).idx, fair_exp[k]);
            chk("fair_beats", dev(k).beats, 1);
        end

        // Payload backpressure.
        step(1);
        clear_logs();
        bp_en = 1'b1;
        want[1] = 1; nbeats[1] = 4;
        wait_done(1, 60);
        chk("bp_idx", dev(0).idx, 1);
        chk("bp_beats", dev(0).beats, 4);
        bp_en = 1'b0;

        // Contention: requester 1 arrives while 3 moves payload.
        step(1);
        clear_logs();
        want[3] = 1; nbeats[3] = 4;
        wait_grant(3, 20);
        step(1);
        want[1] = 1; nbeats[1] = 1;
        wait_done(2, 60);
        chk("cont_first_done", dev(0).idx, 3);
        chk("cont_req_before_done", int'(req_rise[1] < dev(0).cyc), 1);
        chk("cont_second_grant", gev(1).idx, 1);
        chk("cont_grant_gap", gev(1).cyc - dev(0).cyc, 1);

        // Reset in the middle of a payload.
        step(1);
        clear_logs();
        want[3] = 1; nbeats[3] = 6;
        want[1] = 1; nbeats[1] = 2;
        wait_grant(3, 20);
        wait_beats(2, 20);
        rst_n = 1'b0;
        step(1);
        chk("midrst_beat_cnt", int'(arb_beat_cnt), 0);
        chk("midrst_grant_val", int'(arb_grant_val), 0);
        step(1);
        rst_n = 1'b1;
        clear_logs();
        wait_done(2, 80);
        chk("midrst_first_grant", gev(0).idx, 1);
        chk("midrst_second_grant", gev(1).idx, 3);
        chk("midrst_beats1", dev(0).beats, 2);
        chk("midrst_beats3", dev(1).beats, 6);

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/app_wr_buf_arb.md
APP_WR_BUF_ARB -- requirements
Module: app_wr_buf_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of app controllers sharing one wr_buf engine (2..8).
REQ-002 Parameter REQ_IDX_W, default $clog2(NUM_REQ): width of the grant index.
REQ-003 Parameter BEAT_CNT_W, default 16: width of the per-transaction beat counter.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock for all state.
REQ-006 Port rst_n, input, 1, synchronous active-low reset.
REQ-007 Port src_wr_buf_req_val, input, NUM_REQ, per-requester write-buffer request valid.
REQ-008 Port wr_buf_src_req_rdy, output, NUM_REQ, per-requester request ready.
REQ-009 Port src_wr_buf_req_data_val, input, NUM_REQ, per-requester payload beat valid.
REQ-010 Port src_wr_buf_req_data_last, input, NUM_REQ, marks the final payload beat.
REQ-011 Port wr_buf_src_req_data_rdy, output, NUM_REQ, per-requester payload ready.
REQ-012 Port wr_buf_src_req_done, output, NUM_REQ, per-requester completion valid.
REQ-013 Port src_wr_buf_done_rdy, input, NUM_REQ, per-requester completion ready.
REQ-014 Port arb_wr_buf_req_val / wr_buf_arb_req_rdy, output/input, 1 each: shared engine request handshake.
REQ-015 Port arb_wr_buf_req_data_val / wr_buf_arb_req_data_rdy, output/input, 1 each: shared payload handshake.
REQ-016 Port wr_buf_arb_req_done / arb_wr_buf_done_rdy, input/output, 1 each: shared completion handshake.
REQ-017 Port arb_grant_idx, output, REQ_IDX_W, registered index of the owner, selects the datapath payload mux.
REQ-018 Port arb_grant_val, output, 1, high whenever arb_grant_idx is valid (any state but IDLE).
REQ-019 Port arb_beat_cnt, output, BEAT_CNT_W, payload beats accepted in the current transaction.

Function
REQ-020 FSM states: IDLE, REQ, DATA, DONE; one transaction owns the engine from grant to completion handshake.
REQ-021 IDLE: if any req_val is set, pick a winner by round-robin starting at rr_ptr, latch arb_grant_idx, clear arb_beat_cnt, go to REQ the next cycle; no rdy asserted in IDLE.
REQ-022 REQ: arb_wr_buf_req_val = src_wr_buf_req_val[grant]; wr_buf_src_req_rdy[grant] = wr_buf_arb_req_rdy; on handshake go to DATA.
REQ-023 DATA: arb_wr_buf_req_data_val = data_val[grant]; data_rdy[grant] = wr_buf_arb_req_data_rdy; each handshake increments arb_beat_cnt (saturating at all-ones); handshake with data_last[grant] goes to DONE.
REQ-024 DONE: wr_buf_src_req_done[grant] = wr_buf_arb_req_done; arb_wr_buf_done_rdy = src_wr_buf_done_rdy[grant]; on handshake set rr_ptr = grant+1 (modulo NUM_REQ) and go to IDLE.
REQ-025 All per-requester rdy/done outputs for non-granted indices are 0 in every state.
REQ-026 Arbitration is one-cycle registered: grant latency from req_val in IDLE to req_val on shared side is exactly 1 cycle.
REQ-027 Requests arriving while not IDLE wait; a deasserted req_val before REQ handshake keeps the grant (owner must not withdraw).
REQ-028 Single requester: back-to-back transactions to the same index allowed, one IDLE cycle between them.
REQ-029 Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
REQ-030 Single-beat transfer (last on first beat) goes DATA->DONE with arb_beat_cnt = 1.

Reset
REQ-031 rst_n low on a rising edge: state=IDLE, rr_ptr=0, arb_grant_idx=0, arb_beat_cnt=0; all valid/rdy/done outputs 0 in that cycle and the next.
REQ-032 Reset mid-transaction abandons it; no partial handshakes are replayed.

Structure
REQ-033 State enum and the default widths belong in the shared package with existing app state definitions.
REQ-034 Round-robin selection is one sub-module, rr_arbiter_ptr (req vector, rr_ptr -> one-hot winner, index), combinational.

Verification
REQ-035 Reset: rst_n=0 two cycles with all req_val=1 -> no rdy/done/valid asserted, arb_grant_val=0.
REQ-036 Single req: req_val[2]=1, 3 beats, last on beat 3 -> grant_idx=2 one cycle later, beat_cnt=3, done routed only to index 2.
REQ-037 Fairness: all 4 requesting, 1-beat transfers -> grant order 0,1,2,3,0.
REQ-038 Backpressure: wr_buf_arb_req_data_rdy toggles 1/0 over 4 beats -> beat_cnt increments only on handshakes, final 4.
REQ-039 Contention: req_val[1] rises while index 3 is in DATA -> index 1 waits, granted one cycle after index 3 done handshake.
REQ-040 Reset mid-DATA after 2 beats -> IDLE, beat_cnt=0, rr_ptr=0, next grant lowest requesting index.
